// File: rtl/plab5_mcore_mem_req_arbiter_pkg.sv
// rtl/plab5_mcore_mem_req_arbiter_pkg.sv - memory request field widths and cmsg layout helpers
package plab5_mcore_mem_req_arbiter_pkg;

  localparam int c_type_nbits = 3;

  typedef enum logic [2:0] {
    MEM_TYPE_READ  = 3'd0,
    MEM_TYPE_WRITE = 3'd1,
    MEM_TYPE_INIT  = 3'd2
  } mem_type_e;

  function automatic int len_nbits(input int data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  function automatic int cmsg_nbits(input int opaque_nbits, input int addr_nbits,
                                    input int data_nbits);
    return c_type_nbits + opaque_nbits + addr_nbits + len_nbits(data_nbits);
  endfunction

  // cmsg layout from the LSB up: len, addr, opaque, type
  function automatic int addr_lsb(input int data_nbits);
    return len_nbits(data_nbits);
  endfunction

  function automatic int opaque_lsb(input int addr_nbits, input int data_nbits);
    return len_nbits(data_nbits) + addr_nbits;
  endfunction

  function automatic int type_lsb(input int opaque_nbits, input int addr_nbits,
                                  input int data_nbits);
    return len_nbits(data_nbits) + addr_nbits + opaque_nbits;
  endfunction

endpackage

// File: rtl/plab5_mcore_rr_arb.sv
// rtl/plab5_mcore_rr_arb.sv - round-robin arbiter: one-hot grant and next priority pointer
module plab5_mcore_rr_arb #(
  parameter  int p_num_reqs = 2,
  localparam int c_id_nbits = $clog2(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] i_req,
  input  logic                  i_en,
  input  logic [c_id_nbits-1:0] i_ptr,
  output logic [p_num_reqs-1:0] o_grant,
  output logic [c_id_nbits-1:0] o_id,
  output logic [c_id_nbits-1:0] o_ptr_next
);

  logic [c_id_nbits-1:0] w_idx;
  logic                  w_found;

  // Search starts at the pointer and wraps, so the first valid at/after it wins
  always_comb begin
    o_grant    = '0;
    o_id       = '0;
    w_idx      = '0;
    w_found    = 1'b0;
    for (int k = 0; k < p_num_reqs; k++) begin
      w_idx = c_id_nbits'((int'(i_ptr) + k) % p_num_reqs);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
        w_found        = 1'b1;
      end
    end
    o_ptr_next = w_found ? c_id_nbits'((int'(o_id) + 1) % p_num_reqs) : i_ptr;
  end

endmodule

// File: rtl/plab5_mcore_mem_req_arbiter.sv
// rtl/plab5_mcore_mem_req_arbiter.sv - round-robin memory request arbiter with id-stamped opaque and response steering
module plab5_mcore_mem_req_arbiter
  import plab5_mcore_mem_req_arbiter_pkg::*;
#(
  parameter  int p_num_reqs     = 2,
  parameter  int p_opaque_nbits = 8,
  parameter  int p_addr_nbits   = 32,
  parameter  int p_data_nbits   = 32,
  localparam int c_id_nbits     = $clog2(p_num_reqs),
  localparam int c_len_nbits    = len_nbits(p_data_nbits),
  localparam int c_cmsg_nbits   = cmsg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [c_type_nbits*p_num_reqs-1:0] req_type,
  input  logic [p_opaque_nbits*p_num_reqs-1:0] req_opaque,
  input  logic [p_addr_nbits*p_num_reqs-1:0] req_addr,
  input  logic [c_len_nbits*p_num_reqs-1:0]  req_len,
  input  logic [p_data_nbits*p_num_reqs-1:0] req_data,
  input  logic [p_num_reqs-1:0]              req_val,
  output logic [p_num_reqs-1:0]              req_rdy,
  output logic [c_cmsg_nbits-1:0]            mem_req_cmsg,
  output logic [p_data_nbits-1:0]            mem_req_data,
  output logic                               mem_req_val,
  input  logic                               mem_req_rdy,
  input  logic [p_opaque_nbits-1:0]          mem_resp_opaque,
  input  logic                               mem_resp_val,
  output logic                               mem_resp_rdy,
  output logic [p_num_reqs-1:0]              resp_val,
  input  logic [p_num_reqs-1:0]              resp_rdy
);

  logic                      r_val;
  logic [c_id_nbits-1:0]     r_ptr;
  logic [c_cmsg_nbits-1:0]   r_cmsg;
  logic [p_data_nbits-1:0]   r_data;

  logic                      w_can_load;
  logic [p_num_reqs-1:0]     w_grant;
  logic [c_id_nbits-1:0]     w_id;
  logic [c_id_nbits-1:0]     w_ptr_next;
  logic                      w_accept;
  logic [c_type_nbits-1:0]   w_sel_type;
  logic [p_opaque_nbits-1:0] w_sel_opaque;
  logic [p_addr_nbits-1:0]   w_sel_addr;
  logic [c_len_nbits-1:0]    w_sel_len;
  logic [p_data_nbits-1:0]   w_sel_data;
  logic [c_cmsg_nbits-1:0]   w_cmsg;
  logic [c_id_nbits-1:0]     w_resp_id;

  // Grants are masked while reset is asserted so req_rdy reads zero in reset
  assign w_can_load = (!r_val || mem_req_rdy) && reset;

  plab5_mcore_rr_arb #(
    .p_num_reqs (p_num_reqs)
  ) u_rr_arb (
    .i_req      (req_val),
    .i_en       (w_can_load),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_id       (w_id),
    .o_ptr_next (w_ptr_next)
  );

  assign req_rdy  = w_grant;
  assign w_accept = |(w_grant & req_val);

  always_comb begin
    w_sel_type   = req_type[int'(w_id)*c_type_nbits +: c_type_nbits];
    w_sel_opaque = req_opaque[int'(w_id)*p_opaque_nbits +: p_opaque_nbits];
    w_sel_addr   = req_addr[int'(w_id)*p_addr_nbits +: p_addr_nbits];
    w_sel_len    = req_len[int'(w_id)*c_len_nbits +: c_len_nbits];
    w_sel_data   = req_data[int'(w_id)*p_data_nbits +: p_data_nbits];
    w_sel_opaque[c_id_nbits-1:0] = w_id;
    w_cmsg = {w_sel_type, w_sel_opaque, w_sel_addr, w_sel_len};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val  <= 1'b0;
      r_ptr  <= '0;
      r_cmsg <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_val  <= 1'b1;
      r_ptr  <= w_ptr_next;
      r_cmsg <= w_cmsg;
      r_data <= w_sel_data;
    end else if (mem_req_rdy) begin
      r_val  <= 1'b0;
    end
  end

  assign mem_req_val  = r_val;
  assign mem_req_cmsg = r_cmsg;
  assign mem_req_data = r_data;

  // Low opaque bits carry the requester index stamped on the way out
  assign w_resp_id    = mem_resp_opaque[c_id_nbits-1:0];
  assign resp_val     = mem_resp_val ? (p_num_reqs'(1) << w_resp_id) : '0;
  assign mem_resp_rdy = resp_rdy[w_resp_id];

endmodule

// File: tb/tb_plab5_mcore_mem_req_arbiter.sv
// tb/tb_plab5_mcore_mem_req_arbiter.sv - directed bench for the memory request arbiter
module tb_plab5_mcore_mem_req_arbiter;

  localparam logic [44:0] C0 = {3'd0, 8'h34, 32'h0000_1000, 2'd0};
  localparam logic [44:0] C1 = {3'd1, 8'h77, 32'h0000_2000, 2'd3};
  localparam logic [31:0] D0 = 32'hA0A0_0001;
  localparam logic [31:0] D1 = 32'hB1B1_0002;

  logic clk;
  logic reset;

  logic [5:0]  req_type2;
  logic [15:0] req_opaque2;
  logic [63:0] req_addr2;
  logic [3:0]  req_len2;
  logic [63:0] req_data2;
  logic [1:0]  req_val2;
  logic [1:0]  req_rdy2;
  logic [44:0] mem_req_cmsg2;
  logic [31:0] mem_req_data2;
  logic        mem_req_val2;
  logic        mem_req_rdy2;
  logic [7:0]  mem_resp_opaque2;
  logic        mem_resp_val2;
  logic        mem_resp_rdy2;
  logic [1:0]  resp_val2;
  logic [1:0]  resp_rdy2;

  logic [11:0]  req_type4;
  logic [31:0]  req_opaque4;
  logic [127:0] req_addr4;
  logic [7:0]   req_len4;
  logic [127:0] req_data4;
  logic [3:0]   req_val4;
  logic [3:0]   req_rdy4;
  logic [44:0]  mem_req_cmsg4;
  logic [31:0]  mem_req_data4;
  logic         mem_req_val4;
  logic         mem_req_rdy4;
  logic [7:0]   mem_resp_opaque4;
  logic         mem_resp_val4;
  logic         mem_resp_rdy4;
  logic [3:0]   resp_val4;
  logic [3:0]   resp_rdy4;

  int checks = 0;
  int errors = 0;

  plab5_mcore_mem_req_arbiter #(.p_num_reqs(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_type(req_type2), .req_opaque(req_opaque2), .req_addr(req_addr2),
    .req_len(req_len2), .req_data(req_data2), .req_val(req_val2), .req_rdy(req_rdy2),
    .mem_req_cmsg(mem_req_cmsg2), .mem_req_data(mem_req_data2),
    .mem_req_val(mem_req_val2), .mem_req_rdy(mem_req_rdy2),
    .mem_resp_opaque(mem_resp_opaque2), .mem_resp_val(mem_resp_val2),
    .mem_resp_rdy(mem_resp_rdy2), .resp_val(resp_val2), .resp_rdy(resp_rdy2)
  );

  plab5_mcore_mem_req_arbiter #(.p_num_reqs(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_type(req_type4), .req_opaque(req_opaque4), .req_addr(req_addr4),
    .req_len(req_len4), .req_data(req_data4), .req_val(req_val4), .req_rdy(req_rdy4),
    .mem_req_cmsg(mem_req_cmsg4), .mem_req_data(mem_req_data4),
    .mem_req_val(mem_req_val4), .mem_req_rdy(mem_req_rdy4),
    .mem_resp_opaque(mem_resp_opaque4), .mem_resp_val(mem_resp_val4),
    .mem_resp_rdy(mem_resp_rdy4), .resp_val(resp_val4), .resp_rdy(resp_rdy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  val;
    logic        rdy;
    logic [1:0]  exp_rdy;
    logic        exp_val;
    logic [44:0] exp_cmsg;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[16];
  logic [3:0] exp_gnt4[5];
  logic [7:0] exp_opq4[5];

  initial begin
    vecs[0]  = '{2'b00, 1'b1, 2'b00, 1'b0, 45'd0, 32'd0};
    vecs[1]  = '{2'b01, 1'b1, 2'b01, 1'b0, 45'd0, 32'd0};
    vecs[2]  = '{2'b00, 1'b1, 2'b00, 1'b1, C0, D0};
    vecs[3]  = '{2'b11, 1'b1, 2'b10, 1'b0, 45'd0, 32'd0};
    vecs[4]  = '{2'b11, 1'b1, 2'b01, 1'b1, C1, D1};
    vecs[5]  = '{2'b11, 1'b1, 2'b10, 1'b1, C0, D0};
    vecs[6]  = '{2'b11, 1'b0, 2'b00, 1'b1, C1, D1};
    vecs[7]  = '{2'b11, 1'b0, 2'b00, 1'b1, C1, D1};
    vecs[8]  = '{2'b11, 1'b0, 2'b00, 1'b1, C1, D1};
    vecs[9]  = '{2'b11, 1'b1, 2'b01, 1'b1, C1, D1};
    vecs[10] = '{2'b00, 1'b1, 2'b00, 1'b1, C0, D0};
    vecs[11] = '{2'b00, 1'b0, 2'b00, 1'b0, 45'd0, 32'd0};
    vecs[12] = '{2'b10, 1'b0, 2'b10, 1'b0, 45'd0, 32'd0};
    vecs[13] = '{2'b00, 1'b0, 2'b00, 1'b1, C1, D1};
    vecs[14] = '{2'b00, 1'b1, 2'b00, 1'b1, C1, D1};
    vecs[15] = '{2'b00, 1'b1, 2'b00, 1'b0, 45'd0, 32'd0};

    exp_gnt4 = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
    exp_opq4 = '{8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2};

    req_type2   = {3'd1, 3'd0};
    req_opaque2 = {8'h76, 8'h35};
    req_addr2   = {32'h0000_2000, 32'h0000_1000};
    req_len2    = {2'd3, 2'd0};
    req_data2   = {D1, D0};
    req_val2    = 2'b00;
    mem_req_rdy2 = 1'b1;
    mem_resp_opaque2 = 8'h00;
    mem_resp_val2 = 1'b0;
    resp_rdy2 = 2'b00;

    for (int i = 0; i < 4; i++) begin
      req_type4[i*3 +: 3]     = 3'(i);
      req_opaque4[i*8 +: 8]   = 8'hA3;
      req_addr4[i*32 +: 32]   = 32'(32'h100 * i + 32'h40);
      req_len4[i*2 +: 2]      = 2'(i);
      req_data4[i*32 +: 32]   = 32'(32'h1000 + i);
    end
    req_val4 = 4'b0000;
    mem_req_rdy4 = 1'b1;
    mem_resp_opaque4 = 8'h00;
    mem_resp_val4 = 1'b0;
    resp_rdy4 = 4'b0000;

    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_rdy", 64'(req_rdy2), 64'd0);
    chk("reset_mem_val", 64'(mem_req_val2), 64'd0);
    reset = 1'b1;

    // Table-driven: single request, contention, backpressure, drain+accept
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_val2     = vecs[i].val;
      mem_req_rdy2 = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_req_rdy", i), 64'(req_rdy2), 64'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_mem_val", i), 64'(mem_req_val2), 64'(vecs[i].exp_val));
      if (vecs[i].exp_val || i == 0) begin
        chk($sformatf("v%0d_cmsg", i), 64'(mem_req_cmsg2), 64'(vecs[i].exp_cmsg));
        chk($sformatf("v%0d_data", i), 64'(mem_req_data2), 64'(vecs[i].exp_data));
      end
    end

    // Response steering
    mem_resp_val2 = 1'b1; mem_resp_opaque2 = 8'h35; resp_rdy2 = 2'b10; #1;
    chk("resp_val_id1", 64'(resp_val2), 64'b10);
    chk("resp_rdy_id1", 64'(mem_resp_rdy2), 64'd1);
    resp_rdy2 = 2'b01; #1;
    chk("resp_rdy_id1_blocked", 64'(mem_resp_rdy2), 64'd0);
    mem_resp_opaque2 = 8'h34; #1;
    chk("resp_val_id0", 64'(resp_val2), 64'b01);
    chk("resp_rdy_id0", 64'(mem_resp_rdy2), 64'd1);
    mem_resp_val2 = 1'b0; #1;
    chk("resp_val_idle", 64'(resp_val2), 64'd0);
    mem_resp_val4 = 1'b1; mem_resp_opaque4 = 8'hA3; resp_rdy4 = 4'b1000; #1;
    chk("resp4_val_id3", 64'(resp_val4), 64'b1000);
    chk("resp4_rdy_id3", 64'(mem_resp_rdy4), 64'd1);
    mem_resp_val4 = 1'b0;

    // Async reset during a stall: req0 accepted (pointer -> 1) then held
    @(negedge clk);
    req_val2 = 2'b01; mem_req_rdy2 = 1'b0;
    @(negedge clk);
    req_val2 = 2'b00; #1;
    chk("stall_mem_val", 64'(mem_req_val2), 64'd1);
    #2 reset = 1'b0; #1;
    chk("async_rst_mem_val", 64'(mem_req_val2), 64'd0);
    chk("async_rst_cmsg", 64'(mem_req_cmsg2), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    req_val2 = 2'b11; mem_req_rdy2 = 1'b1; #1;
    chk("post_rst_ptr0", 64'(req_rdy2), 64'b01);
    @(negedge clk);
    req_val2 = 2'b00; #1;
    chk("post_rst_cmsg", 64'(mem_req_cmsg2), 64'(C0));

    // Four requesters: steer pointer to 3, then all valid
    @(negedge clk);
    req_val4 = 4'b0100; mem_req_rdy4 = 1'b1; #1;
    chk("r4_first_gnt", 64'(req_rdy4), 64'b0100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_val4 = (k < 4) ? 4'b1111 : 4'b0000;
      #1;
      chk($sformatf("r4_gnt%0d", k), 64'(req_rdy4), 64'(exp_gnt4[k]));
      chk($sformatf("r4_val%0d", k), 64'(mem_req_val4), 64'd1);
      chk($sformatf("r4_opq%0d", k), 64'(mem_req_cmsg4[41:34]), 64'(exp_opq4[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_req_arbiter.md
Name: plab5_mcore_mem_req_arbiter

Overview:
Shares one memory request port between p_num_reqs requesters (e.g. I-cache and D-cache refill/evict paths) using round-robin arbitration. The block stamps each winning request's opaque field with the requester index, builds the control message and data, and holds the result in a one-entry output register. It also routes responses back to their requester by decoding the opaque field. It sits between the per-core cache request ports and the shared memory/network request port.

Parameters:
p_num_reqs, 2, number of requesters; must be 2 or 4.
p_opaque_nbits, 8, opaque field width.
p_addr_nbits, 32, address width.
p_data_nbits, 32, data width.
c_id_nbits, clog2(p_num_reqs), derived; requester index width.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req_type  in  3*p_num_reqs  per-requester type field; requester i occupies slice i
req_opaque  in  o*p_num_reqs  per-requester opaque
req_addr  in  a*p_num_reqs  per-requester address
req_len  in  l*p_num_reqs  per-requester length
req_data  in  d*p_num_reqs  per-requester write data
req_val  in  p_num_reqs  request valid, one bit per requester
req_rdy  out  p_num_reqs  request accepted this cycle, one bit per requester
mem_req_cmsg  out  c  packed control message (type|opaque|addr|len)
mem_req_data  out  d  write data
mem_req_val  out  1  output register holds a request
mem_req_rdy  in  1  memory accepts the request
mem_resp_opaque  in  o  opaque of the incoming response
mem_resp_val  in  1  response valid
mem_resp_rdy  out  1  routed requester ready
resp_val  out  p_num_reqs  response valid, steered to one requester
resp_rdy  in  p_num_reqs  requester response ready

Behaviour:
- Reset (reset low, asynchronous): mem_req_val=0; round-robin priority pointer=0; output register contents=0; req_rdy=0.
- Output register: one entry. It can load when empty or when it drains this cycle (mem_req_val & mem_req_rdy). This gives full throughput of one request per cycle.
- Grant (combinational): a grant is issued only when the register can load. The granted requester is the first valid requester at or after the pointer, searching in increasing index with wrap-around. req_rdy is one-hot on that requester and all zeros otherwise. req_rdy never depends on req_val of other requesters except through selection.
- Accept (req_val[i] & req_rdy[i]) loads the register on the next edge:
  - cmsg = {type_i, opaque_i with low c_id_nbits replaced by i, addr_i, len_i}
  - data = data_i
  - mem_req_val = 1
- Pointer update: on accept, pointer becomes (i+1) mod p_num_reqs. Otherwise it is unchanged. A requester held off for several cycles wins within p_num_reqs grants.
- Register hold: when mem_req_val=1 and mem_req_rdy=0, all outputs are held stable and no grant is issued.
- Simultaneous drain and accept: the new request replaces the drained one in the same edge, and mem_req_val stays 1.
- Drain with no accept: mem_req_val falls to 0 on the next edge.
- Latency: accept to mem_req_val is exactly 1 cycle.
- Response routing (combinational):
  - id = mem_resp_opaque[c_id_nbits-1:0]
  - resp_val[id] = mem_resp_val; all other bits are 0
  - mem_resp_rdy = resp_rdy[id]
  - Requesters restore their own opaque bits; the low id bits are reserved for the arbiter.
- Reset asserted mid-transfer: the pending request is discarded and the pointer returns to 0. Upstream must replay.
- Width rule: type=3 bits, l=clog2(d/8). The total is c = 3+o+a+l; for the defaults c = 3+8+32+2 = 45.

Decomposition:
- Shared package/header holds the field-width macros (type, opaque, addr, len) and the cmsg slice offsets: len at [l-1:0], addr at [l+a-1:l], opaque at [l+a+o-1:l+a], type at the top.
- One sub-module: plab5_mcore_rr_arb. It takes the request vector, an enable and a priority pointer, and produces the one-hot grant and updated pointer. It is reused by the network-side arbiters.
- The packing step uses the existing control-message pack module.

Test Plan:
1. Single requester: req0 sends type=0 (read), opaque=0x35, addr=0x1000, len=0 with mem_req_rdy=1. The next cycle mem_req_val=1, and cmsg carries opaque=0x34 (low bit=0 for id 0) and addr=0x1000.
2. Contention: req0 and req1 hold valid continuously with mem_req_rdy=1. Grants alternate 0,1,0,1, and each requester gets one accept every 2 cycles.
3. Backpressure: mem_req_rdy=0 for 3 cycles while a request is held. cmsg/data stay stable, req_rdy=0; on rdy=1 the drain and next accept happen in the same edge.
4. Response steering: mem_resp_val=1, opaque=0x35 (id 1) with resp_rdy=2'b10. resp_val=2'b10 and mem_resp_rdy=1; with resp_rdy=2'b01, mem_resp_rdy=0.
5. Async reset mid-stall: reset driven low between clock edges. mem_req_val drops immediately, and after release the pointer=0 so req0 wins first under contention.
6. p_num_reqs=4: all four requesters valid with the pointer at 3. The grant order is 3,0,1,2, and the opaque low two bits match the grant index.
